// File: rtl/dec8_pkg.sv
// Shared definitions for the LED/select decoder family: state encoding,
// bus widths and the one-hot decode helper.
package dec8_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned OUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] onehot8(input logic [IDX_W-1:0] idx);
    return OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dec8_seq_if.sv
// Index push handshake between upstream producer and the sequenced decoder.
interface dec8_seq_if;
  import dec8_pkg::*;

  logic [IDX_W-1:0] in_idx;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_idx, output in_valid, input in_ready);
  modport slave  (input in_idx, input in_valid, output in_ready);
endinterface

// File: rtl/idx_fifo.sv
// Small synchronous FIFO holding pending indices; head is read combinationally.
module idx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dec8_seq.sv
// Sequenced 3-to-8 one-hot decoder: queued indices are shown one at a time
// for HOLD_CYCLES, separated by GAP_CYCLES of blank output.
module dec8_seq
  import dec8_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dec8_seq_if.slave              bus,
  output logic [OUT_W-1:0]       out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned HG   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CMAX = (HG > 2) ? HG : 2;
  localparam int unsigned CW   = $clog2(CMAX);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             cnt_zero;

  // Ready depends on registered fill only, so in_valid never reaches in_ready.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign cnt_zero     = (cnt == '0);
  assign busy         = (state != ST_IDLE) || !empty;

  idx_fifo #(.DEPTH(DEPTH), .W(IDX_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_idx),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pop = 1'b0;
    unique case (state)
      ST_IDLE: pop = !empty;
      ST_HOLD: pop = cnt_zero && (GAP_CYCLES == 0) && !empty;
      ST_GAP:  pop = cnt_zero && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            out   <= onehot8(head);
            cnt   <= CW'(HOLD_CYCLES - 1);
            state <= ST_HOLD;
          end else begin
            out <= '0;
          end
        end
        ST_HOLD: begin
          if (!cnt_zero) begin
            cnt <= cnt - CW'(1);
          end else if (GAP_CYCLES > 0) begin
            out   <= '0;
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= ST_GAP;
          end else if (!empty) begin
            out <= onehot8(head);
            cnt <= CW'(HOLD_CYCLES - 1);
          end else begin
            out   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (!cnt_zero) begin
            out <= '0;
            cnt <= cnt - CW'(1);
          end else if (!empty) begin
            out   <= onehot8(head);
            cnt   <= CW'(HOLD_CYCLES - 1);
            state <= ST_HOLD;
          end else begin
            out   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          out   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec8_seq.sv
// Scoreboard bench for dec8_seq: a GAP_CYCLES=1 instance and a GAP_CYCLES=0 instance.
module tb_dec8_seq;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dec8_seq_if ifa ();
  dec8_seq_if ifb ();

  logic [7:0]    out_a, out_b;
  logic          busy_a, busy_b;
  logic [LW-1:0] level_a, level_b;

  dec8_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .out(out_a), .busy(busy_a), .level(level_a)
  );
  dec8_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .out(out_b), .busy(busy_b), .level(level_b)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  int         run = 0;
  int         cyc = 0;
  int         last_start = -1;
  logic [7:0] cur = 8'h00;
  bit         sel_b = 1'b0;
  bit         b2b = 1'b0;

  // Per-cycle monitor: pops the scoreboard at every pattern start and checks hold length/spacing.
  task automatic observe();
    logic [7:0] o;
    logic [7:0] e;
    int g;
    @(negedge clk);
    cyc++;
    o = sel_b ? out_b : out_a;
    g = sel_b ? 0 : int'(GAP);
    n_checks++;
    if (o !== 8'h00 && !$onehot(o)) begin
      n_fail++; $display("FAIL onehot: out=%h required zero or one-hot", o);
    end
    if (o !== 8'h00) begin
      if (run == 0 || run == int'(HOLD)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL pattern: out=%h required 00 (nothing queued)", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_fail++; $display("FAIL pattern: out=%h required %h", o, e);
          end
        end
        if (b2b && last_start >= 0) begin
          n_checks++;
          if (cyc - last_start != int'(HOLD) + g) begin
            n_fail++; $display("FAIL spacing: %0d cycles required %0d", cyc - last_start, int'(HOLD) + g);
          end
        end
        last_start = cyc;
        run = 1;
        cur = o;
      end else begin
        n_checks++;
        if (o !== cur) begin
          n_fail++; $display("FAIL hold_stable: out=%h required %h", o, cur);
        end
        run++;
      end
    end else begin
      if (run != 0 && run != int'(HOLD)) begin
        n_checks++; n_fail++;
        $display("FAIL hold_len: %0d cycles required %0d", run, HOLD);
      end
      run = 0;
    end
  endtask

  task automatic cycle(input logic v, input logic [2:0] idx);
    logic rdy;
    if (sel_b) begin
      ifb.in_valid = v; ifb.in_idx = idx; rdy = ifb.in_ready;
    end else begin
      ifa.in_valid = v; ifa.in_idx = idx; rdy = ifa.in_ready;
    end
    if (v && rdy && !rst) exp_q.push_back(8'h01 << idx);
    observe();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    observe();
    observe();
    n_checks++;
    if (out_a !== 8'h00) begin n_fail++; $display("FAIL reset_out_during: %h required 00", out_a); end
    rst = 1'b0;
    observe();
    n_checks++;
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      n_fail++; $display("FAIL reset_out: a=%h b=%h required 00", out_a, out_b);
    end
    n_checks++;
    if (level_a !== '0 || level_b !== '0) begin
      n_fail++; $display("FAIL reset_level: a=%0d b=%0d required 0", level_a, level_b);
    end
    n_checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: a=%b b=%b required 0", busy_a, busy_b);
    end
    n_checks++;
    if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: a=%b b=%b required 1", ifa.in_ready, ifb.in_ready);
    end
  endtask

  task automatic test_single();
    sel_b = 1'b0; b2b = 1'b0;
    cycle(1'b1, 3'd5);
    n_checks++;
    if (level_a !== LW'(1)) begin n_fail++; $display("FAIL single_level: %0d required 1", level_a); end
    cycle(1'b0, 3'd0);
    n_checks++;
    if (out_a !== 8'h20) begin n_fail++; $display("FAIL single_latency: out=%h required 20", out_a); end
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0);
    cycle(1'b0, 3'd0);
    n_checks++;
    if (out_a !== 8'h00 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL single_gap: out=%h busy=%b required 00/1", out_a, busy_a);
    end
    cycle(1'b0, 3'd0);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: %b required 0", busy_a); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int peak;
    sel_b = 1'b0; b2b = 1'b1; last_start = -1;
    peak = 0;
    cycle(1'b1, 3'd0);
    if (int'(level_a) > peak) peak = int'(level_a);
    cycle(1'b1, 3'd7);
    if (int'(level_a) > peak) peak = int'(level_a);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 3'd0);
      if (int'(level_a) > peak) peak = int'(level_a);
    end
    n_checks++;
    if (peak != 1) begin n_fail++; $display("FAIL b2b_peak_level: %0d required 1", peak); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [2:0] seq [6];
    logic rdy;
    int k;
    sel_b = 1'b0; b2b = 1'b1; last_start = -1;
    seq[0] = 3'd3; seq[1] = 3'd1; seq[2] = 3'd4;
    seq[3] = 3'd1; seq[4] = 3'd5; seq[5] = 3'd2;
    k = 0;
    for (int t = 0; t < 12 && k < 6; t++) begin
      n_checks++;
      if (ifa.in_ready !== ((t == 5 || t == 6) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL ovf_ready t=%0d: %b required %b", t, ifa.in_ready, !(t == 5 || t == 6));
      end
      if (t == 5) begin
        n_checks++;
        if (level_a !== LW'(DEPTH)) begin n_fail++; $display("FAIL ovf_level: %0d required %0d", level_a, DEPTH); end
      end
      rdy = ifa.in_ready;
      cycle(1'b1, seq[k]);
      if (rdy) k++;
    end
    ifa.in_valid = 1'b0;
    n_checks++;
    if (k != 6) begin n_fail++; $display("FAIL ovf_accepted: %0d required 6", k); end
    for (int i = 0; i < 40; i++) cycle(1'b0, 3'd0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_hold();
    bit bad;
    sel_b = 1'b0; b2b = 1'b0;
    bad = 1'b0;
    cycle(1'b1, 3'd3);
    cycle(1'b1, 3'd6);
    cycle(1'b1, 3'd2);
    n_checks++;
    if (out_a !== 8'h08) begin n_fail++; $display("FAIL rst_mid_pre: out=%h required 08", out_a); end
    exp_q.delete();
    run = 0;
    rst = 1'b1;
    cycle(1'b1, 3'd7);
    n_checks++;
    if (out_a !== 8'h00 || level_a !== '0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: out=%h level=%0d busy=%b required 00/0/0", out_a, level_a, busy_a);
    end
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 3'd0);
      if (out_a === 8'h40 || out_a === 8'h04) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL rst_mid_discard: stale pattern seen required none"); end
    n_checks++;
    if (level_a !== '0) begin n_fail++; $display("FAIL rst_mid_level: %0d required 0", level_a); end
  endtask

  task automatic test_no_gap();
    int nz, first_nz, last_nz;
    sel_b = 1'b1; b2b = 1'b1; last_start = -1; run = 0;
    nz = 0; first_nz = -1; last_nz = -1;
    cycle(1'b1, 3'd2);
    cycle(1'b1, 3'd3);
    for (int i = 0; i < 12; i++) begin
      if (out_b !== 8'h00) begin
        nz++; if (first_nz < 0) first_nz = cyc; last_nz = cyc;
      end
      cycle(1'b0, 3'd0);
    end
    n_checks++;
    if (nz != 8 || last_nz - first_nz != 7) begin
      n_fail++; $display("FAIL nogap_run: %0d nonzero over span %0d required 8 over 7", nz, last_nz - first_nz);
    end
    n_checks++;
    if (exp_q.size() != 0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL nogap_drain: left=%0d busy=%b required 0/0", exp_q.size(), busy_b);
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_idx = 3'd0;
    ifb.in_valid = 1'b0; ifb.in_idx = 3'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_hold();
    test_no_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
